// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - request/response handshake bundle for the nibble serial adder sequencer
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - sequences a WIDTH-bit add through an external 4-bit adder, one nibble per clock
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_adder_ctrl_if.slave   bus,
    output logic [3:0]                  add_a,
    output logic [3:0]                  add_b,
    output logic                        add_cin,
    input  logic [3:0]                  add_sum,
    input  logic                        add_cout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_reg, b_reg, result, result_nxt, nib_mask;
    logic               carry;
    logic [CNT_W-1:0]   k;
    logic [CNT_W+1:0]   shamt;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r, ovf_r;

    assign shamt      = {k, 2'b00};
    assign nib_mask   = WIDTH'(4'hF) << shamt;
    assign result_nxt = (result & ~nib_mask) | (WIDTH'(add_sum) << shamt);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (k == LAST_K)  state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = 4'(a_reg >> shamt);
            add_b   = 4'(b_reg >> shamt);
            add_cin = carry;
        end
    end

    // Outputs live in their own registers so they survive the result clear on the next accept.
    assign bus.out_sum  = sum_r;
    assign bus.out_cout = cout_r;
    assign bus.out_ovf  = ovf_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            carry  <= 1'b0;
            k      <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            a_reg  <= bus.in_a;
            b_reg  <= bus.in_b;
            carry  <= bus.in_cin;
            result <= '0;
            k      <= '0;
        end else if (state == RUN) begin
            result <= result_nxt;
            carry  <= add_cout;
            k      <= k + 1'b1;
            if (k == LAST_K) begin
                sum_r  <= result_nxt;
                cout_r <= add_cout;
                ovf_r  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                          (result_nxt[WIDTH-1] != a_reg[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed scoreboard bench for 16-bit and 4-bit sequencer instances
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4 ();

    logic [3:0] add_a16, add_b16, add_sum16, add_a4, add_b4, add_sum4;
    logic       add_cin16, add_cout16, add_cin4, add_cout4;

    assign {add_cout16, add_sum16} = {1'b0, add_a16} + {1'b0, add_b16} + {4'b0, add_cin16};
    assign {add_cout4, add_sum4}   = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};

    nibble_serial_adder_ctrl #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .bus(bus16),
        .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
        .add_sum(add_sum16), .add_cout(add_cout16)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb16[$];
    exp_t sb4[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [3:0] tr_a[0:7];
    logic       tr_cin[0:7];
    int         tr_n;

    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp_t r;
        logic [16:0] s;
        logic [16:0] msk;
        msk    = (17'd1 << w) - 17'd1;
        s      = (17'(a) & msk) + (17'(b) & msk) + 17'(cin);
        r.sum  = 16'(s & msk);
        r.cout = s[w];
        r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus16.in_valid = 1'b1;
        bus16.in_a     = a;
        bus16.in_b     = b;
        bus16.in_cin   = cin;
        chk("acc16_rdy", 32'(bus16.in_ready), 32'd1);
        sb16.push_back(model(16, a, b, cin));
        tick();
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait16(input string tag);
        int c;
        exp_t e;
        c    = 1;
        tr_n = 0;
        while (!bus16.out_valid && c < 40) begin
            if (tr_n < 8) begin
                tr_a[tr_n]   = add_a16;
                tr_cin[tr_n] = add_cin16;
            end
            tr_n++;
            tick();
            c++;
        end
        chk({tag, "_lat"}, 32'(c), 32'd5);
        chk({tag, "_sbq"}, 32'(sb16.size()), 32'd1);
        if (sb16.size() > 0) begin
            e = sb16.pop_front();
            chk({tag, "_sum"},  32'(bus16.out_sum),  32'(e.sum));
            chk({tag, "_cout"}, 32'(bus16.out_cout), 32'(e.cout));
            chk({tag, "_ovf"},  32'(bus16.out_ovf),  32'(e.ovf));
        end
    endtask

    task automatic ack16(input string tag);
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        chk({tag, "_ack_vld"}, 32'(bus16.out_valid), 32'd0);
        chk({tag, "_ack_rdy"}, 32'(bus16.in_ready),  32'd1);
    endtask

    initial begin
        int c;
        exp_t e;
        logic [3:0] exp_a[0:3];
        logic       exp_cin[0:3];

        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid  = 1'b0; bus4.in_a  = '0; bus4.in_b  = '0; bus4.in_cin  = 1'b0; bus4.out_ready  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rdy16",  32'(bus16.in_ready),  32'd1);
        chk("rst_vld16",  32'(bus16.out_valid), 32'd0);
        chk("rst_sum16",  32'(bus16.out_sum),   32'd0);
        chk("rst_cout16", 32'(bus16.out_cout),  32'd0);
        chk("rst_ovf16",  32'(bus16.out_ovf),   32'd0);
        chk("rst_adda16", 32'(add_a16),         32'd0);
        chk("rst_rdy4",   32'(bus4.in_ready),   32'd1);

        start16(16'h1234, 16'h4321, 1'b0);
        wait16("t1");
        exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
        chk("t1_runlen", 32'(tr_n), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_adda%0d", i), 32'(tr_a[i]), 32'(exp_a[i]));
        ack16("t1");

        start16(16'hFFFF, 16'h0001, 1'b0);
        wait16("t2");
        exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) chk($sformatf("t2_cin%0d", i), 32'(tr_cin[i]), 32'(exp_cin[i]));
        ack16("t2");

        start16(16'h7FFF, 16'h0000, 1'b1);
        wait16("t3a");
        ack16("t3a");
        start16(16'h8000, 16'h8000, 1'b0);
        wait16("t3b");
        ack16("t3b");

        start16(16'h1234, 16'h1111, 1'b0);
        wait16("t4");
        bus16.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus16.in_a = 16'(i * 16'h1111 + 5);
            tick();
            chk($sformatf("t4_hold_rdy%0d", i), 32'(bus16.in_ready),  32'd0);
            chk($sformatf("t4_hold_vld%0d", i), 32'(bus16.out_valid), 32'd1);
            chk($sformatf("t4_hold_sum%0d", i), 32'(bus16.out_sum),   32'h2345);
        end
        bus16.in_a = 16'h0001;
        bus16.in_b = 16'h0002;
        bus16.in_cin = 1'b0;
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        chk("t4_idle_vld", 32'(bus16.out_valid), 32'd0);
        chk("t4_idle_rdy", 32'(bus16.in_ready),  32'd1);
        chk("t4_idle_sum", 32'(bus16.out_sum),   32'h2345);
        sb16.push_back(model(16, 16'h0001, 16'h0002, 1'b0));
        tick();
        bus16.in_valid = 1'b0;
        chk("t4_run_rdy", 32'(bus16.in_ready), 32'd0);
        wait16("t4b");
        ack16("t4b");

        start16(16'h1111, 16'h2222, 1'b0);
        sb16.delete();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rdy",  32'(bus16.in_ready),  32'd1);
        chk("t5_vld",  32'(bus16.out_valid), 32'd0);
        chk("t5_sum",  32'(bus16.out_sum),   32'd0);
        chk("t5_cout", 32'(bus16.out_cout),  32'd0);
        start16(16'h0F0F, 16'h00F1, 1'b0);
        wait16("t5");
        ack16("t5");

        bus4.in_valid = 1'b1;
        bus4.in_a     = 4'hF;
        bus4.in_b     = 4'hF;
        bus4.in_cin   = 1'b1;
        chk("t6_acc_rdy", 32'(bus4.in_ready), 32'd1);
        sb4.push_back(model(4, 16'h000F, 16'h000F, 1'b1));
        tick();
        bus4.in_valid = 1'b0;
        c = 1;
        while (!bus4.out_valid && c < 40) begin
            tick();
            c++;
        end
        chk("t6_lat", 32'(c), 32'd2);
        chk("t6_sbq", 32'(sb4.size()), 32'd1);
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            chk("t6_sum",  32'(bus4.out_sum),  32'(e.sum[3:0]));
            chk("t6_cout", 32'(bus4.out_cout), 32'(e.cout));
            chk("t6_ovf",  32'(bus4.out_ovf),  32'(e.ovf));
        end
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        chk("t6_ack_vld", 32'(bus4.out_valid), 32'd0);
        chk("t6_ack_rdy", 32'(bus4.in_ready),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands through the team's 4-bit carry-select adder, one nibble per clock. It sits directly upstream of that adder. It drives the adder's a/b/c_in from shifted operand registers, captures sum/c_out each cycle, and chains the carry into the next nibble. The wide result is returned on a valid/ready output handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4
NIBBLES, WIDTH/4, derived (localparam); number of adder passes per operation

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  high only in IDLE; transfer when in_valid && in_ready
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry into nibble 0
add_a  output  4  to 4-bit adder input a
add_b  output  4  to 4-bit adder input b
add_cin  output  1  to 4-bit adder c_in
add_sum  input  4  from adder sum (combinational, same cycle)
add_cout  input  1  from adder c_out (combinational, same cycle)
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  in_a + in_b + in_cin, modulo 2^WIDTH
out_cout  output  1  carry out of bit WIDTH-1
out_ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; operand/result/carry/counter registers cleared; out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 in the cycle after reset. rst takes priority over all other events, including mid-RUN and in DONE. Any operation in progress is discarded.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. add_a/add_b/add_cin are driven 0. On in_valid=1, latch in_a, in_b and in_cin into the carry register. Clear the result register and nibble counter k=0, then go to RUN.
- RUN: in_ready=0. add_a = A[4k+3:4k] and add_b = B[4k+3:4k], both combinational from the registers; add_cin = carry register. Each edge:
  - result[4k+3:4k] <= add_sum
  - carry <= add_cout
  - k <= k+1
- RUN exit: when k == NIBBLES-1 at the edge, go to DONE.
- Adder path: the adder is purely combinational within the cycle. The block adds no pipeline register on the adder path.
- Latency: the request is accepted at edge 0, and RUN occupies edges 1..NIBBLES. out_valid is asserted after edge NIBBLES+1 is not used: out_valid rises in the cycle following the last RUN edge, i.e. NIBBLES+1 cycles after the accept cycle. For WIDTH=16, out_valid is high 5 cycles after acceptance.
- DONE: out_valid=1. out_sum=result and out_cout=carry; these and out_ovf stay stable while out_ready=0. in_ready=0.
  - out_ovf = (A[WIDTH-1]==B[WIDTH-1]) && (result[WIDTH-1]!=A[WIDTH-1])
  - On out_ready=1, go to IDLE. out_valid drops next cycle; out_sum/out_cout/out_ovf hold their last value until the next DONE.
- Back-to-back requests: there is no overlap. A new request can be accepted no earlier than the cycle after the DONE handshake. Throughput is one op per NIBBLES+2 cycles with out_ready tied high.
- in_valid outside IDLE is ignored. Operands are not sampled and no state changes.
- Counter width: $clog2(NIBBLES), minimum 1 bit. For WIDTH=4 (NIBBLES=1), RUN lasts exactly one edge.
- Wrap-around: the sum is modulo 2^WIDTH, and the carry out of the top nibble appears only on out_cout.

Test Plan:
- WIDTH=16, in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x5555, out_cout=0, out_ovf=0. out_valid rises 5 cycles after the accept. add_a sequence over RUN = 4,3,2,1.
- in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1, out_ovf=0. add_cin over RUN = 0,1,1,1 (carry ripples through every nibble).
- in_a=0x7FFF, in_b=0x0000, in_cin=1 -> out_sum=0x8000, out_cout=0, out_ovf=1. Then in_a=0x8000, in_b=0x8000, in_cin=0 -> out_sum=0x0000, out_cout=1, out_ovf=1.
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and changing in_a -> in_ready stays 0, and out_* are stable at the first result. Raise out_ready -> IDLE next cycle; the second request is accepted only afterwards.
- Assert rst for 1 cycle during the 2nd RUN cycle -> next cycle shows state IDLE, in_ready=1, out_valid=0, out_sum=0. A fresh op 0x0F0F+0x00F1 then yields 0x1000, out_cout=0.
- WIDTH=4 instance: in_a=0xF, in_b=0xF, in_cin=1 -> out_sum=0xF, out_cout=1, out_ovf=0. out_valid rises 2 cycles after the accept.
